// File: rtl/sync_generator.sv
// sync_generator: frame/line sync timing generator.
// A frame is one FSYNC cycle followed by num_lines lines of line_len cycles.
// The pattern configuration is shadowed at each frame start so the
// downstream pattern generator sees values that stay stable for the frame.
module sync_generator (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        cont,
  input  logic [11:0] line_len_i,
  input  logic [4:0]  num_lines_i,
  input  logic [11:0] constVal_i,
  input  logic [1:0]  X_i,
  input  logic [1:0]  Y_i,
  input  logic [2:0]  Mode_i,
  output logic        f_sync,
  output logic        sync,
  output logic [11:0] constVal,
  output logic [1:0]  X,
  output logic [1:0]  Y,
  output logic [2:0]  Mode,
  output logic        busy,
  output logic        frame_done,
  output logic [4:0]  line_idx,
  output logic [11:0] pix_idx
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FSYNC = 2'd1;
  localparam logic [1:0] LINE  = 2'd2;

  logic [1:0]  state;
  logic        stop_pending;
  logic [11:0] len_sh;
  logic [4:0]  lines_sh;
  logic [11:0] len_eff;
  logic [4:0]  lines_eff;
  logic        pix_last;
  logic        line_last;
  logic        frame_end;
  logic        go_again;
  logic        latch;

  // Clamp the incoming geometry and decode end-of-line / end-of-frame.
  always_comb begin
    len_eff   = (line_len_i < 12'd4) ? 12'd4 : line_len_i;
    lines_eff = (num_lines_i == '0) ? 5'd1 : num_lines_i;
    pix_last  = (pix_idx == len_sh - 12'd1);
    line_last = (line_idx == lines_sh - 5'd1);
    frame_end = (state == LINE) && pix_last && line_last;
    // A stop arriving in the final cycle still prevents the next frame.
    go_again  = frame_end && cont && !(stop_pending || stop);
    latch     = ((state == IDLE) && start) || go_again;
  end

  // Shadow the frame configuration at every frame start.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_sh   <= 12'd4;
      lines_sh <= 5'd1;
      constVal <= '0;
      X        <= '0;
      Y        <= '0;
      Mode     <= '0;
    end else if (latch) begin
      len_sh   <= len_eff;
      lines_sh <= lines_eff;
      constVal <= constVal_i;
      X        <= X_i;
      Y        <= Y_i;
      Mode     <= Mode_i;
    end
  end

  // Frame FSM with registered sync/position outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      stop_pending <= 1'b0;
      f_sync       <= 1'b0;
      sync         <= 1'b0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      line_idx     <= '0;
      pix_idx      <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          f_sync   <= 1'b0;
          sync     <= 1'b0;
          busy     <= 1'b0;
          line_idx <= '0;
          pix_idx  <= '0;
          if (start) begin
            state        <= FSYNC;
            f_sync       <= 1'b1;
            busy         <= 1'b1;
            // start together with stop runs a single, non-continuous frame
            stop_pending <= stop;
          end
        end
        FSYNC: begin
          stop_pending <= stop_pending | stop;
          state        <= LINE;
          f_sync       <= 1'b0;
          sync         <= 1'b1;
          busy         <= 1'b1;
          line_idx     <= '0;
          pix_idx      <= '0;
        end
        LINE: begin
          stop_pending <= stop_pending | stop;
          if (frame_end) begin
            frame_done <= 1'b1;
            line_idx   <= '0;
            pix_idx    <= '0;
            sync       <= 1'b0;
            if (go_again) begin
              state  <= FSYNC;
              f_sync <= 1'b1;
              busy   <= 1'b1;
            end else begin
              state        <= IDLE;
              f_sync       <= 1'b0;
              busy         <= 1'b0;
              stop_pending <= 1'b0;
            end
          end else if (pix_last) begin
            pix_idx  <= '0;
            line_idx <= line_idx + 5'd1;
            sync     <= 1'b1;
          end else begin
            pix_idx <= pix_idx + 12'd1;
            sync    <= 1'b0;
          end
        end
        default: begin
          state        <= IDLE;
          stop_pending <= 1'b0;
          f_sync       <= 1'b0;
          sync         <= 1'b0;
          busy         <= 1'b0;
          line_idx     <= '0;
          pix_idx      <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sync_generator.sv
// tb_sync_generator: directed scenarios followed by random traffic, every
// cycle compared against a frame-offset reference model.
module tb_sync_generator;

  logic        clk = 1'b0;
  logic        rst, start, stop, cont;
  logic [11:0] line_len_i, constVal_i;
  logic [4:0]  num_lines_i;
  logic [1:0]  X_i, Y_i;
  logic [2:0]  Mode_i;
  logic        f_sync, sync, busy, frame_done;
  logic [11:0] constVal, pix_idx;
  logic [1:0]  X, Y;
  logic [2:0]  Mode;
  logic [4:0]  line_idx;

  int errors = 0;
  int checks = 0;

  // reference model: a frame is an offset counter 0 .. N*L
  bit          m_act, m_done, m_pend;
  int          m_off, m_L, m_N;
  logic [11:0] m_cv;
  logic [1:0]  m_x, m_y;
  logic [2:0]  m_mode;

  always #8 clk = ~clk;

  sync_generator dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .cont(cont),
    .line_len_i(line_len_i), .num_lines_i(num_lines_i),
    .constVal_i(constVal_i), .X_i(X_i), .Y_i(Y_i), .Mode_i(Mode_i),
    .f_sync(f_sync), .sync(sync), .constVal(constVal), .X(X), .Y(Y),
    .Mode(Mode), .busy(busy), .frame_done(frame_done),
    .line_idx(line_idx), .pix_idx(pix_idx)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_latch();
    m_L    = (int'(line_len_i) < 4) ? 4 : int'(line_len_i);
    m_N    = (num_lines_i == 5'd0) ? 1 : int'(num_lines_i);
    m_cv   = constVal_i;
    m_x    = X_i;
    m_y    = Y_i;
    m_mode = Mode_i;
  endtask

  task automatic model_edge();
    if (rst) begin
      m_act = 0; m_done = 0; m_pend = 0; m_off = 0;
      m_cv = '0; m_x = '0; m_y = '0; m_mode = '0;
    end else begin
      m_done = 0;
      if (!m_act) begin
        if (start) begin
          model_latch();
          m_act = 1; m_off = 0; m_pend = stop;
        end
      end else begin
        m_pend = m_pend | stop;
        if (m_off == m_N * m_L) begin
          m_done = 1;
          if (cont && !m_pend) begin
            model_latch();
            m_off = 0;
          end else begin
            m_act = 0; m_pend = 0; m_off = 0;
          end
        end else begin
          m_off++;
        end
      end
    end
  endtask

  task automatic check_all();
    bit in_line;
    int p, l;
    in_line = m_act && (m_off > 0);
    p = in_line ? (m_off - 1) % m_L : 0;
    l = in_line ? (m_off - 1) / m_L : 0;
    chk("f_sync",     32'(f_sync),     32'(m_act && m_off == 0));
    chk("sync",       32'(sync),       32'(in_line && p == 0));
    chk("busy",       32'(busy),       32'(m_act));
    chk("frame_done", 32'(frame_done), 32'(m_done));
    chk("pix_idx",    32'(pix_idx),    32'(p));
    chk("line_idx",   32'(line_idx),   32'(l));
    chk("constVal",   32'(constVal),   32'(m_cv));
    chk("X",          32'(X),          32'(m_x));
    chk("Y",          32'(Y),          32'(m_y));
    chk("Mode",       32'(Mode),       32'(m_mode));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic cfg(input int len, input int nl, input int md);
    line_len_i  = 12'(len);
    num_lines_i = 5'(nl);
    Mode_i      = 3'(md);
    constVal_i  = 12'(12'h100 + len);
    X_i         = 2'(len);
    Y_i         = 2'(nl);
  endtask

  initial begin
    rst = 1'b1; start = 1'b1; stop = 1'b0; cont = 1'b0;
    cfg(8, 3, 5);
    m_act = 0; m_done = 0; m_pend = 0; m_off = 0; m_L = 4; m_N = 1;
    m_cv = '0; m_x = '0; m_y = '0; m_mode = '0;

    // reset, with start held high throughout
    run(2);
    rst = 1'b0; start = 1'b0;
    run(2);

    // single frame 8x3
    cfg(8, 3, 3);
    start = 1'b1; tick(); start = 1'b0;
    run(30);

    // clamped geometry
    cfg(2, 0, 6);
    start = 1'b1; tick(); start = 1'b0;
    run(10);

    // continuous, Mode changed mid-frame, then stop in second frame
    cfg(8, 3, 1); cont = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    run(10);
    Mode_i = 3'd4;
    run(30);
    stop = 1'b1; tick(); stop = 1'b0;
    run(40);
    cont = 1'b0;

    // reset at pixel 5 of line 1, then clean restart
    cfg(8, 3, 2);
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (m_act && m_off == 14) break;
      tick();
    end
    chk("rst_point_reached", 32'(pix_idx == 12'd5 && line_idx == 5'd1), 32'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    run(2);
    start = 1'b1; tick(); start = 1'b0;
    run(30);

    // start pulsed while busy
    start = 1'b1; tick(); start = 1'b0;
    run(5);
    start = 1'b1; tick(); start = 1'b0;
    run(25);

    // start and stop together with cont=1: one frame only
    cont = 1'b1; cfg(4, 1, 7);
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    run(12);
    cont = 1'b0;

    // random traffic with configuration churn
    for (int i = 0; i < 1500; i++) begin
      line_len_i  = 12'($urandom_range(0, 10));
      num_lines_i = 5'($urandom_range(0, 3));
      constVal_i  = 12'($urandom);
      X_i         = 2'($urandom);
      Y_i         = 2'($urandom);
      Mode_i      = 3'($urandom);
      start       = ($urandom % 8) == 0;
      stop        = ($urandom % 32) == 0;
      if (($urandom % 64) == 0) cont = ~cont;
      rst         = ($urandom % 300) == 0;
      tick();
    end
    rst = 1'b0; start = 1'b0; stop = 1'b0;
    run(60);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sync_generator.md
SYNC_GENERATOR -- requirements
Module: sync_generator

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 clk  input  1  16 ns master clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 start  input  1  single-cycle request to begin a frame; sampled only in IDLE.
REQ-005 stop  input  1  request to end continuous operation after the current frame.
REQ-006 cont  input  1  1 = run frames back-to-back; 0 = single frame.
REQ-007 line_len_i  input  12  cycles per line, sync cycle included.
REQ-008 num_lines_i  input  5  lines per frame.
REQ-009 constVal_i, X_i, Y_i, Mode_i  input  12/2/2/3  pattern configuration, shadowed per frame.
REQ-010 f_sync  output  1  first-sync pulse, one cycle per frame.
REQ-011 sync  output  1  line-start pulse, one cycle per line.
REQ-012 constVal, X, Y, Mode  output  12/2/2/3  frame-stable configuration for the pattern generator.
REQ-013 busy  output  1  high while a frame is in progress.
REQ-014 frame_done  output  1  one-cycle pulse after the last cycle of each frame.
REQ-015 line_idx  output  5, pix_idx  output  12  current line and cycle-in-line position.

Function
REQ-016 The FSM SHALL have states IDLE, FSYNC and LINE; all outputs SHALL be registered.
REQ-017 IDLE->FSYNC on start=1; start in any other state SHALL be ignored.
REQ-018 On the IDLE->FSYNC edge, the block SHALL latch line_len_i, num_lines_i, constVal_i, X_i, Y_i and Mode_i into shadow registers.
REQ-019 Configuration outputs SHALL change only at that latch point; input changes mid-frame SHALL have no effect.
REQ-020 Effective line length SHALL be max(line_len_i, 4); num_lines_i=0 SHALL be treated as 1.
REQ-021 In FSYNC, f_sync=1, sync=0 and busy=1 for exactly one cycle; the next state is LINE with line_idx=0 and pix_idx=0.
REQ-022 In LINE, sync=1 exactly when pix_idx=0.
REQ-023 pix_idx SHALL increment each cycle and wrap to 0 after (line_len-1); line_idx SHALL increment on each wrap.
REQ-024 Frame length SHALL be 1 + num_lines*line_len cycles; busy=1 throughout.
REQ-025 After the last cycle of the final line, frame_done SHALL pulse for one cycle. If cont=1 and no stop is pending, the next state SHALL be FSYNC and the shadow registers SHALL be re-latched on that edge; otherwise the next state SHALL be IDLE.
REQ-026 A stop seen in any non-IDLE cycle SHALL set stop_pending, which clears on entry to IDLE; the current frame SHALL always complete.
REQ-027 If start=1 and stop=1 in the same cycle in IDLE, the block SHALL start one frame and treat it as non-continuous.
REQ-028 In IDLE: f_sync=0, sync=0, busy=0, line_idx=0, pix_idx=0.
REQ-029 Latency from start sampled at edge T: f_sync high in cycle T+1, first sync in cycle T+2.

Reset
REQ-030 rst=1 SHALL force IDLE at the next edge, including mid-frame, and SHALL clear stop_pending.
REQ-031 Reset values: f_sync=0, sync=0, busy=0, frame_done=0, line_idx=0, pix_idx=0, constVal=12'h000, X=2'b00, Y=2'b00, Mode=3'b000.
REQ-032 start asserted during rst SHALL be ignored.

Verification
REQ-033 Single frame, line_len=8, num_lines=3, cont=0, start at edge T -> f_sync at T+1; sync at T+2, T+10, T+18; busy over T+1..T+25; frame_done at T+26; IDLE afterwards.
REQ-034 Clamping, line_len=2, num_lines=0 -> one line of 4 cycles; sync at T+2; frame_done at T+6.
REQ-035 Continuous mode, cont=1, Mode_i changed from 3'd1 to 3'd4 mid-frame -> Mode stays 1 for the whole frame; f_sync recurs in the cycle of frame_done; Mode=4 in the second frame.
REQ-036 Stop mid-frame in continuous mode -> the current frame completes, frame_done pulses, the block enters IDLE, and no further f_sync appears.
REQ-037 rst asserted at pix_idx=5 of line 1 -> the next cycle has all outputs at reset values; a subsequent start yields a clean frame with the REQ-029 timing.
REQ-038 start pulsed while busy -> ignored; frame timing is identical to REQ-033.
